fibgyro_link_ctrl: RTL and testbench

FIBGYRO_LINK_CTRL -- requirements
Module: fibgyro_link_ctrl

---
 rtl/fibgyro_pkg.sv | 22 ++
 rtl/fibgyro_tmo_cnt.sv | 29 ++
 rtl/fibgyro_link_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_fibgyro_link_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fibgyro_pkg.sv
// Shared types and constants for the fibre-gyro UART link controller.
// Pure declarations: no logic, no latency, no flow control.
package fibgyro_pkg;

  localparam int BAUD_W = 13;
  localparam logic [7:0] HDR_DEFAULT = 8'hEB;

  typedef enum logic [2:0] {
    IDLE,
    TX_WAIT,
    TX_WR,
    RX_HUNT,
    RX_RD,
    RX_CAP,
    CHECK
  } state_t;

  function automatic logic is_rx(input state_t s);
    return (s == RX_HUNT) || (s == RX_RD) || (s == RX_CAP);
  endfunction

endpackage

// File: rtl/fibgyro_tmo_cnt.sv
// Response watchdog: tc is high in the cycle that completes TERM enabled counts.
// Combinational tc, clear has priority over enable; no backpressure.
module fibgyro_tmo_cnt #(
  parameter int TERM = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(TERM + 1);

  logic [W-1:0] cnt;

  assign tc = en && !clr && (cnt == W'(TERM - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fibgyro_link_ctrl.sv
// Gyro link: send a TX_LEN-byte command, then hunt/capture/check an RX_LEN-byte reply.
// Strobes are registered (one cycle after TXRDY/RXRDY); UART ready flags are the only backpressure.
module fibgyro_link_ctrl
  import fibgyro_pkg::*;
#(
  parameter int                TX_LEN   = 4,
  parameter int                RX_LEN   = 10,
  parameter logic [7:0]        HDR      = HDR_DEFAULT,
  parameter logic [BAUD_W-1:0] BAUD_DIV = 13'd26,
  parameter int                TMO_CYC  = 20000
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  TRIG,
  input  logic [8*TX_LEN-1:0]   TX_BUF,
  input  logic                  FLT_L,
  input  logic                  FLT_H,
  input  logic                  CLR_FLT,
  input  logic                  TXRDY,
  input  logic                  RXRDY,
  input  logic [7:0]            RX_DATA,
  output logic [BAUD_W-1:0]     BAUD_VAL,
  output logic [7:0]            UART_DATA,
  output logic                  WEN,
  output logic                  OEN,
  output logic                  EN_L,
  output logic                  EN_H,
  output logic                  TX_EN,
  output logic                  RX_EN,
  output logic [8*RX_LEN-1:0]   RX_BUF,
  output logic                  FRAME_OK,
  output logic                  CKSUM_ERR,
  output logic                  TIMEOUT,
  output logic                  BUSY,
  output logic                  FAULT
);

  localparam int TX_IW = (TX_LEN > 1) ? $clog2(TX_LEN) : 1;
  localparam int RX_IW = $clog2(RX_LEN);

  state_t                  state;
  logic [TX_LEN-1:0][7:0]  tx_cmd;
  logic [TX_IW-1:0]        tx_idx;
  logic [RX_LEN-1:0][7:0]  frm;
  logic [RX_IW-1:0]        rx_idx;
  logic                    in_frame;
  logic                    rx_armed;
  logic [7:0]              sum;
  logic                    flt_in;
  logic                    tmo_en;
  logic                    tmo_clr;
  logic                    tmo_tc;

  assign BAUD_VAL = BAUD_DIV;
  assign flt_in   = FLT_L | FLT_H;
  assign EN_L     = ~FAULT;
  assign EN_H     = ~FAULT;
  assign BUSY     = (state != IDLE);
  assign TX_EN    = (state == TX_WAIT) || (state == TX_WR);
  assign RX_EN    = is_rx(state);

  // Every captured byte restarts the inter-byte watchdog.
  assign tmo_en  = is_rx(state);
  assign tmo_clr = !tmo_en || (state == RX_CAP);

  fibgyro_tmo_cnt #(
    .TERM (TMO_CYC)
  ) u_tmo (
    .clk (CLK),
    .rst (RESET),
    .clr (tmo_clr),
    .en  (tmo_en),
    .tc  (tmo_tc)
  );

  // A fault input in the same cycle as CLR_FLT keeps the fault latched.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      FAULT <= 1'b0;
    end else if (flt_in) begin
      FAULT <= 1'b1;
    end else if (CLR_FLT) begin
      FAULT <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      WEN       <= 1'b1;
      OEN       <= 1'b1;
      UART_DATA <= '0;
      RX_BUF    <= '0;
      FRAME_OK  <= 1'b0;
      CKSUM_ERR <= 1'b0;
      TIMEOUT   <= 1'b0;
      tx_cmd    <= '0;
      tx_idx    <= '0;
      frm       <= '0;
      rx_idx    <= '0;
      in_frame  <= 1'b0;
      rx_armed  <= 1'b0;
      sum       <= '0;
    end else begin
      WEN       <= 1'b1;
      OEN       <= 1'b1;
      FRAME_OK  <= 1'b0;
      CKSUM_ERR <= 1'b0;
      TIMEOUT   <= 1'b0;
      // A byte is read only once RXRDY has dropped since the previous read.
      if (!RXRDY) begin
        rx_armed <= 1'b1;
      end

      if (flt_in) begin
        state <= IDLE;
      end else if (tmo_tc) begin
        TIMEOUT <= 1'b1;
        state   <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (TRIG && !FAULT) begin
              tx_cmd <= TX_BUF;
              tx_idx <= '0;
              state  <= TX_WAIT;
            end
          end
          TX_WAIT: begin
            if (TXRDY) begin
              UART_DATA <= tx_cmd[tx_idx];
              WEN       <= 1'b0;
              state     <= TX_WR;
            end
          end
          TX_WR: begin
            if (tx_idx == TX_IW'(TX_LEN - 1)) begin
              rx_idx   <= '0;
              in_frame <= 1'b0;
              sum      <= '0;
              state    <= RX_HUNT;
            end else begin
              tx_idx <= tx_idx + 1'b1;
              state  <= TX_WAIT;
            end
          end
          RX_HUNT: begin
            if (RXRDY && rx_armed) begin
              OEN      <= 1'b0;
              rx_armed <= 1'b0;
              state    <= RX_RD;
            end
          end
          RX_RD: begin
            state <= RX_CAP;
          end
          RX_CAP: begin
            state <= RX_HUNT;
            if (!in_frame) begin
              if (RX_DATA == HDR) begin
                frm[0]   <= RX_DATA;
                rx_idx   <= RX_IW'(1);
                in_frame <= 1'b1;
                sum      <= '0;
              end
            end else begin
              frm[rx_idx] <= RX_DATA;
              if (rx_idx == RX_IW'(RX_LEN - 1)) begin
                state <= CHECK;
              end else begin
                sum    <= sum + RX_DATA;
                rx_idx <= rx_idx + 1'b1;
              end
            end
          end
          CHECK: begin
            if (frm[RX_LEN-1] == sum) begin
              RX_BUF   <= frm;
              FRAME_OK <= 1'b1;
            end else begin
              CKSUM_ERR <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fibgyro_link_ctrl.sv
// Directed bench for fibgyro_link_ctrl with scoreboard queues for UART writes and status pulses.
module tb_fibgyro_link_ctrl;

  localparam int TX_LEN = 4;
  localparam int RX_LEN = 10;
  localparam int TMO    = 300;

  logic                CLK = 1'b0;
  logic                RESET;
  logic                TRIG;
  logic [8*TX_LEN-1:0] TX_BUF;
  logic                FLT_L, FLT_H, CLR_FLT;
  logic                TXRDY, RXRDY;
  logic [7:0]          RX_DATA;
  logic [12:0]         BAUD_VAL;
  logic [7:0]          UART_DATA;
  logic                WEN, OEN, EN_L, EN_H, TX_EN, RX_EN;
  logic [8*RX_LEN-1:0] RX_BUF;
  logic                FRAME_OK, CKSUM_ERR, TIMEOUT, BUSY, FAULT;

  always #5 CLK = ~CLK;

  fibgyro_link_ctrl #(
    .TX_LEN   (TX_LEN),
    .RX_LEN   (RX_LEN),
    .HDR      (8'hEB),
    .BAUD_DIV (13'd26),
    .TMO_CYC  (TMO)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .TRIG      (TRIG),
    .TX_BUF    (TX_BUF),
    .FLT_L     (FLT_L),
    .FLT_H     (FLT_H),
    .CLR_FLT   (CLR_FLT),
    .TXRDY     (TXRDY),
    .RXRDY     (RXRDY),
    .RX_DATA   (RX_DATA),
    .BAUD_VAL  (BAUD_VAL),
    .UART_DATA (UART_DATA),
    .WEN       (WEN),
    .OEN       (OEN),
    .EN_L      (EN_L),
    .EN_H      (EN_H),
    .TX_EN     (TX_EN),
    .RX_EN     (RX_EN),
    .RX_BUF    (RX_BUF),
    .FRAME_OK  (FRAME_OK),
    .CKSUM_ERR (CKSUM_ERR),
    .TIMEOUT   (TIMEOUT),
    .BUSY      (BUSY),
    .FAULT     (FAULT)
  );

  // code bits: {FRAME_OK, CKSUM_ERR, TIMEOUT}; cyc < 0 means timing not checked
  typedef struct {
    logic [2:0]  code;
    logic [79:0] buf_v;
    longint      cyc;
  } ev_t;

  ev_t         ev_q[$];
  logic [7:0]  tx_exp_q[$];
  logic [79:0] exp_buf;
  int          n_chk = 0;
  int          n_fail = 0;
  longint      cyc = 0;
  longint      last_wen_cyc = 0;
  logic        txrdy_q = 1'b0;
  int          tx_gap = 4;

  localparam logic [79:0] F1 = {8'h24, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'hEB};
  localparam logic [79:0] F2 = {8'h25, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'hEB};
  localparam logic [79:0] F3 = {8'hFB, 8'h80, 8'h70, 8'h60, 8'h50, 8'h40, 8'hEB, 8'h20, 8'h10, 8'hEB};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge CLK) begin
    cyc     <= cyc + 1;
    txrdy_q <= TXRDY;
  end

  // UART transmitter model: busy for a few cycles after each write.
  initial begin
    TXRDY = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RESET && !WEN) begin
        TXRDY  = 1'b0;
        tx_gap = 4;
      end else if (tx_gap > 0) begin
        tx_gap--;
      end else begin
        TXRDY = 1'b1;
      end
    end
  end

  // Write monitor: each WEN-low cycle pops one expected command byte.
  always @(negedge CLK) begin
    if (!RESET && !WEN) begin
      last_wen_cyc = cyc;
      if (tx_exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL tx_unexpected: got write %0h expected none", UART_DATA);
      end else begin
        chk("tx_byte", UART_DATA, tx_exp_q.pop_front());
        chk("tx_after_txrdy", txrdy_q, 1'b1);
      end
    end
  end

  // Status monitor: every pulse cycle pops one expected event.
  always @(negedge CLK) begin
    if (!RESET && (FRAME_OK || CKSUM_ERR || TIMEOUT)) begin
      if (ev_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL ev_unexpected: got %b expected none", {FRAME_OK, CKSUM_ERR, TIMEOUT});
      end else begin
        ev_t e;
        e = ev_q.pop_front();
        chk("ev_code", {FRAME_OK, CKSUM_ERR, TIMEOUT}, e.code);
        chk("ev_rx_buf", RX_BUF, e.buf_v);
        if (e.cyc >= 0) chk("ev_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic push_ev(input logic [2:0] code, input longint c);
    ev_t e;
    e.code  = code;
    e.buf_v = exp_buf;
    e.cyc   = c;
    ev_q.push_back(e);
  endtask

  task automatic wait_ev(input int lim);
    int n = 0;
    while (ev_q.size() != 0 && n < lim) begin
      @(negedge CLK);
      n++;
    end
    chk("ev_delivered", ev_q.size(), 0);
    @(negedge CLK);
  endtask

  task automatic run_cmd(input logic [31:0] cmd);
    int n = 0;
    for (int i = 0; i < TX_LEN; i++) tx_exp_q.push_back(cmd[8*i +: 8]);
    TX_BUF = cmd;
    TRIG   = 1'b1;
    @(negedge CLK);
    TRIG = 1'b0;
    chk("busy_tx", {BUSY, TX_EN, RX_EN}, 3'b110);
    while (tx_exp_q.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("tx_done", tx_exp_q.size(), 0);
    @(negedge CLK);
    chk("rx_phase", {BUSY, TX_EN, RX_EN}, 3'b101);
  endtask

  task automatic present_byte(input logic [7:0] b);
    int n = 0;
    RX_DATA = b;
    RXRDY   = 1'b1;
    do begin
      @(negedge CLK);
      n++;
    end while (OEN !== 1'b0 && n < 100);
    chk("rd_strobe", OEN, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    present_byte(b);
    RXRDY = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [79:0] f);
    for (int i = 0; i < RX_LEN; i++) send_byte(f[8*i +: 8]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; TRIG = 1'b0; TX_BUF = '0;
    FLT_L = 1'b0; FLT_H = 1'b0; CLR_FLT = 1'b0;
    RXRDY = 1'b0; RX_DATA = '0;
    exp_buf = '0;
    repeat (3) @(negedge CLK);

    chk("rst_strobes", {WEN, OEN}, 2'b11);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_fault", {FAULT, EN_L, EN_H}, 3'b011);
    chk("rst_xcvr", {TX_EN, RX_EN}, 2'b00);
    chk("rst_rx_buf", RX_BUF, 80'h0);
    chk("rst_uart_data", UART_DATA, 8'h00);
    chk("rst_pulses", {FRAME_OK, CKSUM_ERR, TIMEOUT}, 3'b000);
    chk("baud_val", BAUD_VAL, 13'd26);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // Good frame
    run_cmd(32'h04030201);
    exp_buf = F1;
    push_ev(3'b100, -1);
    send_frame(F1);
    wait_ev(100);
    chk("idle_after_ok", BUSY, 1'b0);

    // Noise then a bad checksum; last good frame must survive
    run_cmd(32'hA55A3CC3);
    push_ev(3'b010, -1);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(F2);
    wait_ev(100);

    // Silence: timeout counted from the release of the last write strobe
    run_cmd(32'h0000FF80);
    push_ev(3'b001, last_wen_cyc + TMO + 1);
    wait_ev(TMO + 50);
    chk("idle_after_tmo", BUSY, 1'b0);

    // Supply fault mid-reception
    run_cmd(32'h11223344);
    send_byte(8'hEB);
    send_byte(8'h01);
    send_byte(8'h02);
    FLT_H = 1'b1;
    @(negedge CLK);
    chk("flt_latched", {FAULT, EN_L, EN_H}, 3'b100);
    chk("flt_abort", {BUSY, RX_EN}, 2'b00);
    FLT_H = 1'b0;
    TRIG  = 1'b1;
    @(negedge CLK);
    TRIG = 1'b0;
    @(negedge CLK);
    chk("trig_ignored", {BUSY, FAULT}, 2'b01);
    repeat (5) @(negedge CLK);
    FLT_H   = 1'b1;
    CLR_FLT = 1'b1;
    @(negedge CLK);
    chk("flt_beats_clr", FAULT, 1'b1);
    FLT_H = 1'b0;
    @(negedge CLK);
    CLR_FLT = 1'b0;
    chk("flt_cleared", {FAULT, EN_L, EN_H}, 3'b011);
    FLT_L = 1'b1;
    @(negedge CLK);
    FLT_L = 1'b0;
    chk("flt_l_latched", {FAULT, EN_L, EN_H}, 3'b100);
    CLR_FLT = 1'b1;
    @(negedge CLK);
    CLR_FLT = 1'b0;
    chk("flt_l_cleared", {FAULT, EN_L, EN_H}, 3'b011);

    // Reset while byte 5 of a frame is being read
    run_cmd(32'h87654321);
    for (int i = 0; i < 4; i++) send_byte(F3[8*i +: 8]);
    present_byte(F3[39:32]);
    #2 RESET = 1'b1;
    #1;
    chk("arst_busy", {BUSY, TX_EN, RX_EN}, 3'b000);
    chk("arst_strobes", {WEN, OEN}, 2'b11);
    chk("arst_rx_buf", RX_BUF, 80'h0);
    chk("arst_uart_data", UART_DATA, 8'h00);
    exp_buf = '0;
    RXRDY = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // Full frame after reset; embedded header-valued byte is ordinary data
    run_cmd(32'hDEADBEEF);
    exp_buf = F3;
    push_ev(3'b100, -1);
    send_frame(F3);
    wait_ev(100);
    chk("final_rx_buf", RX_BUF, F3);

    chk("tx_queue_drained", tx_exp_q.size(), 0);
    chk("ev_queue_drained", ev_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
